// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war button input path.
package tug_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/tug_input_if.sv
// Player-button bundle: raw button levels and enable in, move pulses out.
interface tug_input_if;

    logic raw_L;
    logic raw_R;
    logic enable;
    logic L;
    logic R;

    modport master (
        output raw_L,
        output raw_R,
        output enable,
        input  L,
        input  R
    );

    modport slave (
        input  raw_L,
        input  raw_R,
        input  enable,
        output L,
        output R
    );

endinterface

// File: rtl/key_conditioner.sv
// One button channel: 2-flop synchronizer, debounce FSM with counter,
// and a registered single-cycle press event.
module key_conditioner
    import tug_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0] sync_reg;
    logic       sync;
    key_state_t state_reg, state_next;
    logic [CW-1:0] count_reg, count_next;
    logic       press_reg, press_next;

    assign sync  = sync_reg[1];
    assign press = press_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg  <= '0;
            state_reg <= IDLE;
            count_reg <= '0;
            press_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], raw};
            state_reg <= state_next;
            count_reg <= count_next;
            press_reg <= press_next;
        end
    end

    // The >= compare keeps the counter from running past the acceptance point.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        press_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (sync) begin
                    state_next = PRESS_WAIT;
                    count_next = CW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!sync) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (count_reg >= LAST) begin
                    state_next = HELD;
                    count_next = '0;
                    press_next = 1'b1;
                end else begin
                    count_next = count_reg + CW'(1);
                end
            end
            HELD: begin
                if (!sync) begin
                    state_next = RELEASE_WAIT;
                    count_next = CW'(1);
                end
            end
            RELEASE_WAIT: begin
                if (sync) begin
                    state_next = HELD;
                    count_next = '0;
                end else if (count_reg >= LAST) begin
                    state_next = IDLE;
                    count_next = '0;
                end else begin
                    count_next = count_reg + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

endmodule

// File: rtl/tug_input.sv
// Two debounced button channels feeding registered, mutually exclusive
// left/right move pulses; ties are dropped and enable gates the outputs.
module tug_input
    import tug_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    tug_input_if.slave  bus
);

    logic [1:0] raw_vec;
    logic [1:0] press_vec;
    logic       l_reg, l_next;
    logic       r_reg, r_next;

    // Bit 0 is the left player, bit 1 the right player.
    assign raw_vec = {bus.raw_R, bus.raw_L};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_key
            key_conditioner #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_key (
                .clk   (clk),
                .reset (reset),
                .raw   (raw_vec[gi]),
                .press (press_vec[gi])
            );
        end
    endgenerate

    // A same-cycle tie cancels both moves; disabled presses are simply lost.
    always_comb begin
        l_next = press_vec[0] & ~press_vec[1] & bus.enable;
        r_next = press_vec[1] & ~press_vec[0] & bus.enable;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            l_reg <= 1'b0;
            r_reg <= 1'b0;
        end else begin
            l_reg <= l_next;
            r_reg <= r_next;
        end
    end

    assign bus.L = l_reg;
    assign bus.R = r_reg;

endmodule

// File: tb/tb_tug_input.sv
// Directed bench for tug_input: a per-cycle vector table plus a
// hand-written asynchronous reset mid-hold sequence.
module tb_tug_input;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    tug_input_if bus ();

    tug_input #(
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic rl;
        logic rr;
        logic en;
        logic el;
        logic er;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;
    int   stepno = 0;

    // Append len cycles of constant inputs; pl/pr mark the cycle index
    // within the segment where a one-cycle L/R pulse is expected (-1: none).
    task automatic seg(input logic rl, input logic rr, input logic en,
                       input int len, input int pl, input int pr);
        for (int i = 0; i < len; i++) begin
            vec_t v;
            v.rl = rl;
            v.rr = rr;
            v.en = en;
            v.el = (i == pl);
            v.er = (i == pr);
            vecs.push_back(v);
        end
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled
    // 1 time unit after the following rising edge.
    task automatic step(input logic rl, input logic rr, input logic en,
                        input logic el, input logic er, input string tag);
        bus.raw_L  = rl;
        bus.raw_R  = rr;
        bus.enable = en;
        @(posedge clk);
        #1;
        $display("step %0d %s rawL=%b rawR=%b en=%b L=%b R=%b (exp %b %b)",
                 stepno, tag, rl, rr, en, bus.L, bus.R, el, er);
        check({tag, " L"}, bus.L, el);
        check({tag, " R"}, bus.R, er);
        check({tag, " L&R exclusive"}, bus.L & bus.R, 1'b0);
        stepno++;
    endtask

    initial begin
        bus.raw_L  = 1'b0;
        bus.raw_R  = 1'b0;
        bus.enable = 1'b1;
        reset      = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset L", bus.L, 1'b0);
        check("reset R", bus.R, 1'b0);
        reset = 1'b1;

        // Quiet start
        seg(0, 0, 1, 5, -1, -1);
        // Clean left press held 20 cycles: pulse 6 edges after rise
        seg(1, 0, 1, 20, 6, -1);
        seg(0, 0, 1, 10, -1, -1);
        // Right bounce 1,0,1,0 then hold: one pulse 6 edges after final rise
        seg(0, 1, 1, 1, -1, -1);
        seg(0, 0, 1, 1, -1, -1);
        seg(0, 1, 1, 1, -1, -1);
        seg(0, 0, 1, 1, -1, -1);
        seg(0, 1, 1, 15, -1, 6);
        seg(0, 0, 1, 10, -1, -1);
        // Short release glitch while held: no second pulse
        seg(0, 1, 1, 15, -1, 6);
        seg(0, 0, 1, 2, -1, -1);
        seg(0, 1, 1, 10, -1, -1);
        seg(0, 0, 1, 10, -1, -1);
        // Simultaneous press dropped, then left alone pulses
        seg(1, 1, 1, 10, -1, -1);
        seg(0, 0, 1, 10, -1, -1);
        seg(1, 0, 1, 15, 6, -1);
        seg(0, 0, 1, 10, -1, -1);
        // Press accepted while disabled never pulses later
        seg(0, 0, 0, 3, -1, -1);
        seg(1, 0, 0, 10, -1, -1);
        seg(1, 0, 1, 5, -1, -1);
        seg(0, 0, 1, 10, -1, -1);
        seg(1, 0, 1, 15, 6, -1);
        seg(0, 0, 1, 10, -1, -1);
        // Five right press/release cycles
        for (int k = 0; k < 5; k++) begin
            seg(0, 1, 1, 10, -1, 6);
            seg(0, 0, 1, 10, -1, -1);
        end

        foreach (vecs[i]) begin
            step(vecs[i].rl, vecs[i].rr, vecs[i].en, vecs[i].el, vecs[i].er, "vec");
        end

        // Reset mid-hold: drop reset while the pulse is high
        for (int k = 0; k < 7; k++) begin
            step(1, 0, 1, (k == 6), 0, "rst_pre");
        end
        reset = 1'b0;
        #1;
        check("rst async L", bus.L, 1'b0);
        check("rst async R", bus.R, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            $display("step %0d rst_hold rawL=1 L=%b R=%b (exp 0 0)", stepno, bus.L, bus.R);
            check("rst hold L", bus.L, 1'b0);
            check("rst hold R", bus.R, 1'b0);
            stepno++;
        end
        reset = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step(1, 0, 1, (k == 6), 0, "rst_post");
        end
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 1, 0, 0, "rst_release");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
